// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encoding and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_NOR  = 4'b1100
    } alu_op_e;

endpackage

// File: rtl/alu_core_comb.sv
// Purely combinational ALU datapath: result, zero detect and signed overflow for ADD/SUB.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    // SLT uses a true signed compare rather than the sign of diff, so it stays correct on overflow
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_control)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SUB: begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_NOR:  result = ~(a | b);
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_32bit.sv
// Execute-stage ALU top: combinational core followed by one register stage with a valid pipeline.
module alu_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_overflow;

    logic [WIDTH-1:0] result_d,   result_q;
    logic             zero_d,     zero_q;
    logic             overflow_d, overflow_q;
    logic             valid_d,    valid_q;

    alu_core_comb #(
        .WIDTH(WIDTH)
    ) u_core (
        .a          (a),
        .b          (b),
        .alu_control(alu_control),
        .result     (core_result),
        .zero       (core_zero),
        .overflow   (core_overflow)
    );

    // Idle cycles keep the last result and flags; only out_valid drops
    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        valid_d    = in_valid;
        if (in_valid) begin
            result_d   = core_result;
            zero_d     = core_zero;
            overflow_d = core_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign result    = result_q;
    assign zero_flag = zero_q;
    assign overflow  = overflow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed test-plan vectors plus randomized traffic against an arithmetic model.
module tb_alu_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero_flag;
    logic        overflow;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_ov;
    logic        exp_valid;

    always #5 clk = ~clk;

    alu_32bit dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .alu_control(alu_control),
        .result     (result),
        .zero_flag  (zero_flag),
        .overflow   (overflow),
        .out_valid  (out_valid)
    );

    // Reference model in plain 64-bit integer arithmetic
    function automatic logic [31:0] refCalc(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, output logic ov);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'd0, x});
        longint uy = longint'({32'd0, y});
        longint n  = longint'({59'd0, y[4:0]});
        longint pw = longint'(1) << n;
        longint t;
        logic [31:0] r;
        ov = 1'b0;
        r  = 32'd0;
        case (op)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2: begin
                t  = sx + sy;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd3:  r = x ^ y;
            4'd4: begin
                t = ux * pw;
                r = t[31:0];
            end
            4'd5: begin
                t = ux / pw;
                r = t[31:0];
            end
            4'd6: begin
                t  = sx - sy;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd8:  r = (ux < uy) ? 32'd1 : 32'd0;
            4'd9: begin
                t = sx >>> n;
                r = t[31:0];
            end
            4'd12: r = ~(x | y);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic applyStimulus(input logic rst, input logic vld, input logic [3:0] op,
                                 input logic [31:0] op_a, input logic [31:0] op_b);
        logic ov;
        logic [31:0] r;
        reset       = rst;
        in_valid    = vld;
        alu_control = op;
        a           = op_a;
        b           = op_b;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_result = 32'd0;
            exp_zero   = 1'b1;
            exp_ov     = 1'b0;
            exp_valid  = 1'b0;
        end else begin
            exp_valid = vld;
            if (vld) begin
                r          = refCalc(op, op_a, op_b, ov);
                exp_result = r;
                exp_zero   = (r == 32'd0);
                exp_ov     = ov;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        total++;
        assert (result === exp_result) else begin
            bad++;
            $error("[TB] FAIL %s result: got %h expected %h", tag, result, exp_result);
        end
        total++;
        assert (zero_flag === exp_zero) else begin
            bad++;
            $error("[TB] FAIL %s zero_flag: got %b expected %b", tag, zero_flag, exp_zero);
        end
        total++;
        assert (overflow === exp_ov) else begin
            bad++;
            $error("[TB] FAIL %s overflow: got %b expected %b", tag, overflow, exp_ov);
        end
        total++;
        assert (out_valid === exp_valid) else begin
            bad++;
            $error("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_valid);
        end
    endtask

    task automatic checkLiteral(input string tag, input logic [31:0] want_result, input logic want_ov);
        total++;
        assert (result === want_result) else begin
            bad++;
            $error("[TB] FAIL %s literal result: got %h expected %h", tag, result, want_result);
        end
        total++;
        assert (overflow === want_ov) else begin
            bad++;
            $error("[TB] FAIL %s literal overflow: got %b expected %b", tag, overflow, want_ov);
        end
    endtask

    initial begin
        logic        rst;
        logic        vld;
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        $display("[TB] starting alu_32bit bench");

        applyStimulus(1'b1, 1'b1, 4'b0010, 32'h1234_5678, 32'h1);
        applyStimulus(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
        checkOutput("reset");
        checkLiteral("reset", 32'h0, 1'b0);

        applyStimulus(1'b0, 1'b1, 4'b0000, 32'h0110_1111, 32'h0000_1111);
        checkOutput("and");
        checkLiteral("and", 32'h0000_1111, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0001, 32'h1001_0110, 32'h0110_1111);
        checkOutput("or");
        checkLiteral("or", 32'h1111_1111, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0010, 32'h1010_1111, 32'h0110_1111);
        checkOutput("add");
        checkLiteral("add", 32'h1120_2222, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        checkOutput("add_ovf");
        checkLiteral("add_ovf", 32'h8000_0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'b0110, 32'h1010_1111, 32'h1000_1011);
        checkOutput("sub");
        checkLiteral("sub", 32'h0010_0100, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0110, 32'h1010_1111, 32'h1010_1111);
        checkOutput("sub_zero");
        checkLiteral("sub_zero", 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0110, 32'h8000_0000, 32'h1);
        checkOutput("sub_ovf");
        checkLiteral("sub_ovf", 32'h7FFF_FFFF, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'b0111, 32'h0000_1111, 32'h0110_1111);
        checkOutput("slt");
        checkLiteral("slt", 32'h1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0111, 32'h8000_0000, 32'h1);
        checkOutput("slt_neg");
        checkLiteral("slt_neg", 32'h1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b1000, 32'h8000_0000, 32'h1);
        checkOutput("sltu");
        checkLiteral("sltu", 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b1001, 32'h8000_0000, 32'h4);
        checkOutput("sra");
        checkLiteral("sra", 32'hF800_0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0101, 32'h8000_0000, 32'h4);
        checkOutput("srl");
        checkLiteral("srl", 32'h0800_0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0100, 32'h1, 32'h25);
        checkOutput("sll");
        checkLiteral("sll", 32'h20, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0100, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        checkOutput("sll_zero_shift");
        checkLiteral("sll_zero_shift", 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checkOutput("xor");
        checkLiteral("xor", 32'h0FF0_0FF0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b1100, 32'h0, 32'h0);
        checkOutput("nor");
        checkLiteral("nor", 32'hFFFF_FFFF, 1'b0);

        // Hold behaviour: load a known nonzero value, then idle and verify it stays
        applyStimulus(1'b0, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        checkOutput("pre_gap");
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        checkOutput("gap1");
        checkLiteral("gap1", 32'h8000_0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'b1111, 32'h5, 32'h5);
        checkOutput("gap2");

        applyStimulus(1'b0, 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("undef");
        checkLiteral("undef", 32'h0, 1'b0);

        applyStimulus(1'b0, 1'b1, 4'b0001, 32'hA5A5_0000, 32'h0000_5A5A);
        checkOutput("pre_reset");
        applyStimulus(1'b1, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        checkOutput("mid_reset");
        checkLiteral("mid_reset", 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            vld = ($urandom_range(0, 4) != 0);
            op  = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = 32'($urandom_range(0, 40));
                2:       rb = {ra[31], 31'($urandom)};
                default: rb = $urandom;
            endcase
            applyStimulus(rst, vld, op, ra, rb);
            checkOutput("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
